// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the multi-cycle MIPS core: opcode/funct
// constants, register-bank write-port select encodings, write-back
// exception codes, the write-back sequencer state type and the decoded
// write plan handed from wb_decode to wb_sequencer.
package mips_ctrl_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2b;
    localparam logic [5:0] OP_PUSH   = 6'h3e;
    localparam logic [5:0] OP_POP    = 6'h3f;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;

    // Destination register select
    localparam logic [2:0] RD_RT = 3'b000;
    localparam logic [2:0] RD_RA = 3'b001;
    localparam logic [2:0] RD_SP = 3'b010;
    localparam logic [2:0] RD_RD = 3'b011;
    localparam logic [2:0] RD_RS = 3'b100;

    // Write-data source select
    localparam logic [2:0] WB_ALU    = 3'b000;
    localparam logic [2:0] WB_MDR    = 3'b001;
    localparam logic [2:0] WB_PC     = 3'b010;
    localparam logic [2:0] WB_HI     = 3'b011;
    localparam logic [2:0] WB_LO     = 3'b100;
    localparam logic [2:0] WB_SP_ADJ = 3'b101;

    // Exception codes
    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_OVF     = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE1,
        S_WAIT_MEM,
        S_WRITE2,
        S_FINISH
    } wb_state_t;

    // Decoded write-back plan for one instruction
    typedef struct packed {
        logic [1:0] wr_cnt;  // 0, 1 or 2 register writes
        logic [2:0] dst1;
        logic [2:0] src1;
        logic [2:0] dst2;
        logic [2:0] src2;
        logic [1:0] exc;     // EXC_NONE when the instruction is legal
    } wb_plan_t;

endpackage

// File: rtl/wb_decode.sv
// Combinational write-back decoder.
// Maps opcode/funct/ovf to a write plan: number of register writes, the
// reg_dst/wb_src pair for each write and the exception class.
// Macro WB_STACK_OPS_EN: when defined, push/pop decode as stack writes;
// otherwise they decode as illegal.
// Ports:
//   opcode  in  6  IR[31:26]
//   funct   in  6  IR[5:0]
//   ovf     in  1  ALU overflow flag
//   plan    out    decoded write plan (wb_plan_t)
module wb_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       ovf,
    output wb_plan_t   plan
);

    always_comb begin
        plan = '0;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    plan.wr_cnt = 2'd0;
                end else if (ovf && (funct == FN_ADD || funct == FN_SUB)) begin
                    plan.exc = EXC_OVF;
                end else begin
                    plan.wr_cnt = 2'd1;
                    plan.dst1   = RD_RD;
                    if (funct == FN_MFHI)      plan.src1 = WB_HI;
                    else if (funct == FN_MFLO) plan.src1 = WB_LO;
                    else                       plan.src1 = WB_ALU;
                end
            end
            OP_ADDI: begin
                if (ovf) begin
                    plan.exc = EXC_OVF;
                end else begin
                    plan.wr_cnt = 2'd1;
                    plan.dst1   = RD_RT;
                    plan.src1   = WB_ALU;
                end
            end
            OP_ADDIU, OP_SLTI, OP_ANDI, OP_LUI: begin
                plan.wr_cnt = 2'd1;
                plan.dst1   = RD_RT;
                plan.src1   = WB_ALU;
            end
            OP_LW: begin
                plan.wr_cnt = 2'd1;
                plan.dst1   = RD_RT;
                plan.src1   = WB_MDR;
            end
            OP_JAL: begin
                plan.wr_cnt = 2'd1;
                plan.dst1   = RD_RA;
                plan.src1   = WB_PC;
            end
`ifdef WB_STACK_OPS_EN
            OP_PUSH: begin
                plan.wr_cnt = 2'd1;
                plan.dst1   = RD_SP;
                plan.src1   = WB_SP_ADJ;
            end
            OP_POP: begin
                // rt first, $29 second: with rt == 29 the SP update wins
                plan.wr_cnt = 2'd2;
                plan.dst1   = RD_RT;
                plan.src1   = WB_MDR;
                plan.dst2   = RD_SP;
                plan.src2   = WB_SP_ADJ;
            end
`endif
            OP_REGIMM, OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_SB, OP_SH, OP_SW: begin
                plan.wr_cnt = 2'd0;
            end
            default: begin
                plan.exc = EXC_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer for the multi-cycle MIPS core.
// Accepts a one-cycle start from the main FSM, then drives the register
// bank write port (reg_dst, wb_src, reg_write) for zero, one or two
// writes, and reports completion (done) and exceptions (exc/exc_code).
// Macro WB_STACK_OPS_EN: when defined, push/pop are supported and the
// WAIT_MEM/WRITE2 states plus the mem_ready timeout counter exist;
// otherwise mem_ready is ignored.
// Parameters:
//   MEM_TIMEOUT  cycles spent in WAIT_MEM before a timeout exception
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous active-low reset
//   start      in   1  request pulse, ignored unless idle
//   opcode     in   6  IR[31:26], sampled on acceptance
//   funct      in   6  IR[5:0], sampled on acceptance
//   ovf        in   1  ALU overflow, sampled on acceptance
//   mem_ready  in   1  MDR holds valid read data
//   reg_dst    out  3  destination select (000 outside write cycles)
//   wb_src     out  3  data source select (000 outside write cycles)
//   reg_write  out  1  register bank write enable
//   busy       out  1  operation in progress
//   done       out  1  completion pulse
//   exc        out  1  exception pulse, coincident with done
//   exc_code   out  2  last exception code, held until next acceptance
module wb_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       ovf,
    input  logic       mem_ready,
    output logic [2:0] reg_dst,
    output logic [2:0] wb_src,
    output logic       reg_write,
    output logic       busy,
    output logic       done,
    output logic       exc,
    output logic [1:0] exc_code
);

    wb_plan_t  plan;
    wb_state_t state, state_nx;

    logic [2:0] reg_dst_nx, wb_src_nx;
    logic       reg_write_nx, busy_nx, done_nx, exc_nx;
    logic [1:0] exc_code_nx;

    wb_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .ovf    (ovf),
        .plan   (plan)
    );

`ifdef WB_STACK_OPS_EN
    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    // The plan is decoded from the live inputs at acceptance and kept here,
    // since pop reaches its writes only after the memory wait.
    wb_plan_t      plan_q, plan_q_nx;
    logic [CW-1:0] cnt, cnt_nx;
`else
    logic unused_stack;
    assign unused_stack = &{1'b0, mem_ready, plan.dst2, plan.src2};
`endif

    always_comb begin
        state_nx     = state;
        reg_dst_nx   = '0;
        wb_src_nx    = '0;
        reg_write_nx = 1'b0;
        done_nx      = 1'b0;
        exc_nx       = 1'b0;
        exc_code_nx  = exc_code;
`ifdef WB_STACK_OPS_EN
        plan_q_nx    = plan_q;
        cnt_nx       = cnt;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    exc_code_nx = plan.exc;
`ifdef WB_STACK_OPS_EN
                    plan_q_nx   = plan;
`endif
                    if (plan.exc != EXC_NONE) begin
                        state_nx = S_FINISH;
                        done_nx  = 1'b1;
                        exc_nx   = 1'b1;
                    end else if (plan.wr_cnt == 2'd0) begin
                        state_nx = S_FINISH;
                        done_nx  = 1'b1;
`ifdef WB_STACK_OPS_EN
                    end else if (plan.wr_cnt == 2'd2) begin
                        state_nx = S_WAIT_MEM;
                        cnt_nx   = '0;
`endif
                    end else begin
                        state_nx     = S_WRITE1;
                        reg_write_nx = 1'b1;
                        reg_dst_nx   = plan.dst1;
                        wb_src_nx    = plan.src1;
                    end
                end
            end
            S_WRITE1: begin
`ifdef WB_STACK_OPS_EN
                if (plan_q.wr_cnt == 2'd2) begin
                    state_nx     = S_WRITE2;
                    reg_write_nx = 1'b1;
                    reg_dst_nx   = plan_q.dst2;
                    wb_src_nx    = plan_q.src2;
                end else begin
                    state_nx = S_FINISH;
                    done_nx  = 1'b1;
                end
`else
                state_nx = S_FINISH;
                done_nx  = 1'b1;
`endif
            end
`ifdef WB_STACK_OPS_EN
            S_WAIT_MEM: begin
                // mem_ready takes priority over the timeout in the last wait cycle
                if (mem_ready) begin
                    state_nx     = S_WRITE1;
                    reg_write_nx = 1'b1;
                    reg_dst_nx   = plan_q.dst1;
                    wb_src_nx    = plan_q.src1;
                end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
                    state_nx    = S_FINISH;
                    done_nx     = 1'b1;
                    exc_nx      = 1'b1;
                    exc_code_nx = EXC_TIMEOUT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_WRITE2: begin
                state_nx = S_FINISH;
                done_nx  = 1'b1;
            end
`endif
            S_FINISH: begin
                // start coincident with done is dropped
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        busy_nx = (state_nx == S_WRITE1) || (state_nx == S_WAIT_MEM) ||
                  (state_nx == S_WRITE2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            reg_dst   <= '0;
            wb_src    <= '0;
            reg_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            exc       <= 1'b0;
            exc_code  <= '0;
`ifdef WB_STACK_OPS_EN
            plan_q    <= '0;
            cnt       <= '0;
`endif
        end else begin
            state     <= state_nx;
            reg_dst   <= reg_dst_nx;
            wb_src    <= wb_src_nx;
            reg_write <= reg_write_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            exc       <= exc_nx;
            exc_code  <= exc_code_nx;
`ifdef WB_STACK_OPS_EN
            plan_q    <= plan_q_nx;
            cnt       <= cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer with a timeline-level reference
// model: for each instruction it predicts which writes happen, in which
// cycle after start, and when done/exc arrive.
module tb_wb_sequencer;

    localparam int TO = 15;
`ifdef WB_STACK_OPS_EN
    localparam bit STACK = 1'b1;
`else
    localparam bit STACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       ovf = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] reg_dst, wb_src;
    logic       reg_write, busy, done, exc;
    logic [1:0] exc_code;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .opcode    (opcode),
        .funct     (funct),
        .ovf       (ovf),
        .mem_ready (mem_ready),
        .reg_dst   (reg_dst),
        .wb_src    (wb_src),
        .reg_write (reg_write),
        .busy      (busy),
        .done      (done),
        .exc       (exc),
        .exc_code  (exc_code)
    );

    // Model predictions
    int         exp_nw, exp_done;
    int         exp_wc[2];
    logic [2:0] exp_wd[2], exp_ws[2];
    logic [1:0] exp_code;

    // Observations
    int         obs_nw, obs_done;
    int         obs_wc[2];
    logic [2:0] obs_wd[2], obs_ws[2];
    logic       obs_exc;
    logic [1:0] obs_code, obs_code_hold;
    bit         hs_bad, idle_bad, extra;

    int unsigned op_pool[18] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0f,
                                 6'h23, 6'h03, 6'h3e, 6'h3f, 6'h3f, 6'h04, 6'h2b, 6'h02,
                                 6'h11, 6'h20};
    int unsigned fn_pool[7] = '{6'h20, 6'h22, 6'h08, 6'h10, 6'h12, 6'h21, 6'h2a};

    task automatic one_write(input logic [2:0] dst, input logic [2:0] src);
        exp_nw = 1; exp_wc[0] = 1; exp_wd[0] = dst; exp_ws[0] = src; exp_done = 2;
    endtask

    // d = cycles mem_ready stays low after start; it rises in cycle start+1+d
    task automatic predict(input logic [5:0] op, input logic [5:0] fn, input logic ov,
                           input int d);
        exp_nw = 0; exp_code = 2'd0; exp_done = 1;
        exp_wc[0] = 0; exp_wc[1] = 0;
        exp_wd[0] = 0; exp_wd[1] = 0; exp_ws[0] = 0; exp_ws[1] = 0;
        if (op == 6'h00) begin
            if (fn == 6'h08) exp_nw = 0;
            else if (ov && (fn == 6'h20 || fn == 6'h22)) exp_code = 2'd1;
            else one_write(3'd3, (fn == 6'h10) ? 3'd3 : ((fn == 6'h12) ? 3'd4 : 3'd0));
        end else if (op == 6'h08 && ov) exp_code = 2'd1;
        else if (op inside {6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0f}) one_write(3'd0, 3'd0);
        else if (op == 6'h23) one_write(3'd0, 3'd1);
        else if (op == 6'h03) one_write(3'd1, 3'd2);
        else if (STACK && op == 6'h3e) one_write(3'd2, 3'd5);
        else if (STACK && op == 6'h3f) begin
            if (d < TO) begin
                exp_nw = 2;
                exp_wc[0] = d + 2; exp_wd[0] = 3'd0; exp_ws[0] = 3'd1;
                exp_wc[1] = d + 3; exp_wd[1] = 3'd2; exp_ws[1] = 3'd5;
                exp_done = d + 4;
            end else begin
                exp_code = 2'd3; exp_done = TO + 1;
            end
        end else if (op inside {6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07,
                                6'h28, 6'h29, 6'h2b}) exp_nw = 0;
        else exp_code = 2'd2;
    endtask

    // Issue one instruction and record what the DUT does; hold keeps start
    // high (with scrambled fields) through the done cycle.
    task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic ov,
                        input int d, input bit hold);
        obs_nw = 0; obs_done = -1; obs_exc = 0; obs_code = 0;
        hs_bad = 0; idle_bad = 0; extra = 0;
        obs_wc[0] = 0; obs_wc[1] = 0;
        obs_wd[0] = 0; obs_wd[1] = 0; obs_ws[0] = 0; obs_ws[1] = 0;
        @(negedge clk);
        opcode = op; funct = fn; ovf = ov; start = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 60 && obs_done < 0; k++) begin
            @(negedge clk);
            start     = hold;
            opcode    = 6'($urandom);
            funct     = 6'($urandom);
            ovf       = 1'($urandom);
            mem_ready = (k >= d + 1);
            if (reg_write) begin
                if (obs_nw < 2) begin
                    obs_wc[obs_nw] = k; obs_wd[obs_nw] = reg_dst; obs_ws[obs_nw] = wb_src;
                end
                obs_nw++;
            end else if (reg_dst != 3'd0 || wb_src != 3'd0) idle_bad = 1;
            if (done) begin
                obs_done = k; obs_exc = exc; obs_code = exc_code;
                if (busy) hs_bad = 1;
            end else if (!busy || exc) hs_bad = 1;
        end
        start = 1'b0; mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (busy || reg_write || done || exc) extra = 1;
        end
        obs_code_hold = exc_code;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({reg_dst, wb_src, reg_write, busy, done, exc, exc_code} !== '0)
            begin bad++; $display("FAIL reset_state got=%b exp=0",
                {reg_dst, wb_src, reg_write, busy, done, exc, exc_code}); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rtype_add;
        exec(6'h00, 6'h20, 1'b0, 0, 1'b0);
        total++;
        if (obs_nw !== 1 || obs_wc[0] !== 1 || obs_wd[0] !== 3'b011 || obs_ws[0] !== 3'b000)
            begin bad++; $display("FAIL add_write got n=%0d cyc=%0d dst=%b src=%b exp n=1 cyc=1 dst=011 src=000",
                obs_nw, obs_wc[0], obs_wd[0], obs_ws[0]); end
        total++;
        if (obs_done !== 2) begin bad++; $display("FAIL add_done got=%0d exp=2", obs_done); end
    endtask

    task automatic test_jal_mfhi;
        exec(6'h03, 6'h00, 1'b0, 0, 1'b0);
        total++;
        if (obs_nw !== 1 || obs_wc[0] !== 1 || obs_wd[0] !== 3'b001 || obs_ws[0] !== 3'b010)
            begin bad++; $display("FAIL jal_write got n=%0d cyc=%0d dst=%b src=%b exp n=1 cyc=1 dst=001 src=010",
                obs_nw, obs_wc[0], obs_wd[0], obs_ws[0]); end
        exec(6'h00, 6'h10, 1'b0, 0, 1'b0);
        total++;
        if (obs_nw !== 1 || obs_wd[0] !== 3'b011 || obs_ws[0] !== 3'b011)
            begin bad++; $display("FAIL mfhi_write got n=%0d dst=%b src=%b exp n=1 dst=011 src=011",
                obs_nw, obs_wd[0], obs_ws[0]); end
    endtask

    task automatic test_ovf;
        exec(6'h08, 6'h00, 1'b1, 0, 1'b0);
        total++;
        if (obs_nw !== 0 || obs_done !== 1 || obs_exc !== 1'b1 || obs_code !== 2'b01)
            begin bad++; $display("FAIL addi_ovf got n=%0d done=%0d exc=%b code=%b exp n=0 done=1 exc=1 code=01",
                obs_nw, obs_done, obs_exc, obs_code); end
        exec(6'h00, 6'h22, 1'b1, 0, 1'b0);
        total++;
        if (obs_nw !== 0 || obs_code !== 2'b01 || obs_code_hold !== 2'b01)
            begin bad++; $display("FAIL sub_ovf got n=%0d code=%b hold=%b exp n=0 code=01 hold=01",
                obs_nw, obs_code, obs_code_hold); end
    endtask

    task automatic test_pop;
        exec(6'h3f, 6'h00, 1'b0, 3, 1'b0);
`ifdef WB_STACK_OPS_EN
        total++;
        if (obs_nw !== 2 || obs_wc[0] !== 5 || obs_wd[0] !== 3'b000 || obs_ws[0] !== 3'b001)
            begin bad++; $display("FAIL pop_w1 got n=%0d cyc=%0d dst=%b src=%b exp n=2 cyc=5 dst=000 src=001",
                obs_nw, obs_wc[0], obs_wd[0], obs_ws[0]); end
        total++;
        if (obs_wc[1] !== 6 || obs_wd[1] !== 3'b010 || obs_ws[1] !== 3'b101 || obs_done !== 7)
            begin bad++; $display("FAIL pop_w2 got cyc=%0d dst=%b src=%b done=%0d exp cyc=6 dst=010 src=101 done=7",
                obs_wc[1], obs_wd[1], obs_ws[1], obs_done); end
`else
        total++;
        if (obs_nw !== 0 || obs_done !== 1 || obs_code !== 2'b10)
            begin bad++; $display("FAIL pop_illegal got n=%0d done=%0d code=%b exp n=0 done=1 code=10",
                obs_nw, obs_done, obs_code); end
`endif
    endtask

    task automatic test_timeout;
        // start held high while busy must not queue a second operation
        exec(6'h3f, 6'h00, 1'b0, 1000, 1'b1);
`ifdef WB_STACK_OPS_EN
        total++;
        if (obs_nw !== 0 || obs_done !== TO + 1 || obs_exc !== 1'b1 || obs_code !== 2'b11)
            begin bad++; $display("FAIL timeout got n=%0d done=%0d exc=%b code=%b exp n=0 done=%0d exc=1 code=11",
                obs_nw, obs_done, obs_exc, obs_code, TO + 1); end
`else
        total++;
        if (obs_code !== 2'b10) begin bad++; $display("FAIL pop_illegal2 got=%b exp=10", obs_code); end
`endif
        total++;
        if (extra !== 1'b0 || hs_bad !== 1'b0)
            begin bad++; $display("FAIL busy_drop got extra=%b hs=%b exp 0 0", extra, hs_bad); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            exec(6'h00, 6'h21, 1'b0, 0, 1'b1);
            total++;
            if (obs_nw !== 1 || obs_done !== 2 || extra !== 1'b0 || obs_code_hold !== 2'b00)
                begin bad++; $display("FAIL b2b[%0d] got n=%0d done=%0d extra=%b hold=%b exp n=1 done=2 extra=0 hold=00",
                    i, obs_nw, obs_done, extra, obs_code_hold); end
        end
    endtask

    task automatic test_reset_midop;
        bit wrote = 0;
        @(negedge clk);
        opcode = STACK ? 6'h3f : 6'h23; funct = 6'h00; ovf = 1'b0;
        start = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef WB_STACK_OPS_EN
        @(negedge clk);
`endif
        total++;
        if (reg_write !== 1'b1) begin bad++; $display("FAIL midop_write1 got=%b exp=1", reg_write); end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({reg_dst, wb_src, reg_write, busy, done, exc, exc_code} !== '0)
            begin bad++; $display("FAIL midop_async got=%b exp=0",
                {reg_dst, wb_src, reg_write, busy, done, exc, exc_code}); end
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (reg_write || busy || done) wrote = 1;
        end
        total++;
        if (wrote !== 1'b0) begin bad++; $display("FAIL midop_no_write2 got=%b exp=0", wrote); end
        exec(6'h23, 6'h00, 1'b0, 0, 1'b0);
        total++;
        if (obs_nw !== 1 || obs_wc[0] !== 1 || obs_ws[0] !== 3'b001 || obs_done !== 2)
            begin bad++; $display("FAIL midop_restart got n=%0d cyc=%0d src=%b done=%0d exp n=1 cyc=1 src=001 done=2",
                obs_nw, obs_wc[0], obs_ws[0], obs_done); end
    endtask

    task automatic test_random;
        logic [5:0] op, fn;
        logic       ov;
        int         d;
        bit         h;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom % 4 == 0) ? 6'($urandom) : 6'(op_pool[$urandom % 18]);
            fn = ($urandom % 4 == 0) ? 6'($urandom) : 6'(fn_pool[$urandom % 7]);
            ov = 1'($urandom);
            d  = $urandom_range(0, 20);
            h  = 1'($urandom);
            predict(op, fn, ov, d);
            exec(op, fn, ov, d, h);
            total++;
            if (obs_nw !== exp_nw)
                begin bad++; $display("FAIL rnd%0d nwrites op=%h fn=%h ovf=%b got=%0d exp=%0d",
                    i, op, fn, ov, obs_nw, exp_nw); end
            for (int j = 0; j < 2; j++) begin
                if (j < exp_nw) begin
                    total++;
                    if (obs_wc[j] !== exp_wc[j] || obs_wd[j] !== exp_wd[j] || obs_ws[j] !== exp_ws[j])
                        begin bad++; $display("FAIL rnd%0d write%0d op=%h got cyc=%0d dst=%b src=%b exp cyc=%0d dst=%b src=%b",
                            i, j, op, obs_wc[j], obs_wd[j], obs_ws[j], exp_wc[j], exp_wd[j], exp_ws[j]); end
                end
            end
            total++;
            if (obs_done !== exp_done)
                begin bad++; $display("FAIL rnd%0d done op=%h got=%0d exp=%0d", i, op, obs_done, exp_done); end
            total++;
            if (obs_exc !== (exp_code != 2'd0) || obs_code !== exp_code || obs_code_hold !== exp_code)
                begin bad++; $display("FAIL rnd%0d exc op=%h fn=%h got exc=%b code=%b hold=%b exp code=%b",
                    i, op, fn, obs_exc, obs_code, obs_code_hold, exp_code); end
            total++;
            if (hs_bad !== 1'b0 || idle_bad !== 1'b0 || extra !== 1'b0)
                begin bad++; $display("FAIL rnd%0d protocol op=%h got hs=%b idle=%b extra=%b exp 0 0 0",
                    i, op, hs_bad, idle_bad, extra); end
        end
    endtask

    initial begin
        test_reset;
        test_rtype_add;
        test_jal_mfhi;
        test_ovf;
        test_pop;
        test_timeout;
        test_back_to_back;
        test_reset_midop;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Write-back sequencer for the multi-cycle MIPS core. It takes a one-cycle `start` from the main control FSM once execute/memory work is done. It then drives the register-bank write port: the 3-bit destination-mux select, the write-data source select and `reg_write`. Single-write instructions finish in one write cycle; stack instructions do two ordered writes behind a memory-ready handshake with a timeout.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum cycles spent waiting for `mem_ready` before an error is flagged.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle request from main FSM; ignored while `busy`.
- `opcode`  in  6  IR[31:26], sampled when `start` is accepted.
- `funct`  in  6  IR[5:0], sampled with `opcode`.
- `ovf`  in  1  ALU overflow flag, sampled with `opcode`.
- `mem_ready`  in  1  memory read data valid in MDR.
- `reg_dst`  out  3  destination select: 000 rt, 001 $31, 010 $29, 011 rd, 100 rs.
- `wb_src`  out  3  data select: 000 ALUOut, 001 MDR, 010 PC, 011 HI, 100 LO, 101 SP_ADJ.
- `reg_write`  out  1  register-bank write enable.
- `busy`  out  1  high from acceptance until `done`.
- `done`  out  1  one-cycle completion pulse.
- `exc`  out  1  one-cycle pulse: overflow, illegal opcode or memory timeout.
- `exc_code`  out  2  01 overflow, 10 illegal, 11 timeout; held until next accepted `start`.

## Operation
- States: IDLE, WRITE1, WAIT_MEM, WRITE2, FINISH.
- In IDLE, when `start` is high, latch `opcode`, `funct` and `ovf`, then decode:
  - R-type (opcode 0x00): write `rd`. Data is ALUOut, or HI for funct 0x10, or LO for funct 0x12. The funct 0x08 (jr) case does no write.
  - addi/addiu/slti/andi/lui (0x08/0x09/0x0a/0x0c/0x0f): write `rt` from ALUOut.
  - lw (0x23): write `rt` from MDR.
  - jal (0x03): write `$31` from PC.
  - push (0x3e): write `$29` from SP_ADJ.
  - pop (0x3f): go to WAIT_MEM. The first write is `rt` from MDR; the second is `$29` from SP_ADJ.
  - branch/jump/store opcodes: no write; go straight to FINISH.
  - anything else: illegal.
- If the latched `ovf` is high for add (0x20), sub (0x22) or addi: suppress the write, pulse `exc` with code 01, and go to FINISH.
- Illegal opcode: no write, `exc` with code 10.
- In WAIT_MEM, a counter increments each cycle.
  - When `mem_ready` is high, go to WRITE1.
  - When the counter reaches `MEM_TIMEOUT` and `mem_ready` is low, pulse `exc` with code 11, do no writes, and go to FINISH.
- WRITE2 always follows WRITE1 for pop. `$29` is never written before `rt`.
- If pop has `rt` = 29, the second write wins: `$29` ends up holding SP_ADJ.
- `reg_dst`/`wb_src` are registered outputs. Outside write cycles they hold 000.

## Timing
- Reset (`reset` = 0), effective immediately and asynchronously:
  - State goes to IDLE.
  - `reg_dst`, `wb_src`, `reg_write`, `busy`, `done`, `exc` and `exc_code` all go to 0.
  - The counter clears.
- Reset in mid-operation aborts with no further write.
- Single-write instruction: `start` at cycle T gives `reg_write`=1 at T+1. `done` is at T+2 and `busy` drops at T+2.
- No-write / exception path: `done` at T+1. `exc` is in the same cycle as `done`.
- Pop with `mem_ready` high at T+1: WRITE1 at T+2, WRITE2 at T+3, `done` at T+4.
- `reg_write` is never high for more than one consecutive cycle per write. `reg_dst`/`wb_src` are stable in the same cycle as `reg_write`.
- `start` while `busy` is dropped and does not queue. `start` in the same cycle as `done` is also dropped.

## Configuration
- `WB_STACK_OPS_EN` defined: push/pop are decoded as above, and WAIT_MEM, WRITE2 and the timeout counter are present.
- Not defined: 0x3e/0x3f decode as illegal (code 10). WAIT_MEM/WRITE2 and the counter are not synthesized. The `mem_ready` input is kept but unused.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants (`OP_RTYPE`, `OP_JAL`, `OP_LW`, `OP_PUSH`, `OP_POP`, …) and funct constants;
  - `reg_dst` encodings (`RD_RT`, `RD_RA`, `RD_SP`, `RD_RD`, `RD_RS`);
  - `wb_src` encodings;
  - `exc_code` values;
  - the state enum.
- One sub-module, `wb_decode`: purely combinational. It maps opcode/funct/ovf to write count, first and second `reg_dst`/`wb_src`, and exception class. The top level holds the FSM and counter.

## Test plan
- R-type add, `ovf`=0, start at T → T+1: `reg_dst`=011, `wb_src`=000, `reg_write`=1; `done` at T+2.
- jal → T+1: `reg_dst`=001, `wb_src`=010, one write; mfhi → `reg_dst`=011, `wb_src`=011.
- addi with `ovf`=1 → no `reg_write`; `exc`=1 and `exc_code`=01 at T+1 together with `done`.
- pop, `mem_ready` delayed 3 cycles:
  - with `WB_STACK_OPS_EN`: rt/MDR write, then 010/101 write on the next cycle, then `done`;
  - without `WB_STACK_OPS_EN`: `exc_code`=10.
- pop with `mem_ready` stuck low → after 15 wait cycles, `exc_code`=11 with no write. A second `start` while `busy` is ignored.
- Reset asserted during WRITE1 of pop → all outputs 0 immediately, no WRITE2 afterwards, and the next `start` is accepted normally.
